// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and lock-state encoding, used by both the sync
// generator and the receive-side sync decoder.
package vga_timing_pkg;

    localparam int H_TOTAL  = 800;
    localparam int H_ACTIVE = 640;
    localparam int V_TOTAL  = 525;
    localparam int V_ACTIVE = 480;

    localparam int DEFAULT_LOCK_FRAMES = 2;

    typedef logic [1:0] lock_state_t;

    localparam lock_state_t UNLOCKED = 2'd0;
    localparam lock_state_t TRACKING = 2'd1;
    localparam lock_state_t LOCKED   = 2'd2;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int count_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_sync_decoder_if.sv
// Sync inputs and recovered-timing outputs of the VGA sync decoder.
interface vga_sync_decoder_if import vga_timing_pkg::*; #(
    parameter int TOTAL_COLS = H_TOTAL,
    parameter int TOTAL_ROWS = V_TOTAL
);

    localparam int COL_W = $clog2(TOTAL_COLS);
    localparam int ROW_W = $clog2(TOTAL_ROWS);

    logic             i_H_sync;
    logic             i_V_sync;
    logic [COL_W-1:0] o_Col;
    logic [ROW_W-1:0] o_Row;
    logic             o_Active;
    logic             o_Frame_Start;
    logic             o_Locked;
    logic             o_Err;

    modport master (
        output i_H_sync,
        output i_V_sync,
        input  o_Col,
        input  o_Row,
        input  o_Active,
        input  o_Frame_Start,
        input  o_Locked,
        input  o_Err
    );

    modport slave (
        input  i_H_sync,
        input  i_V_sync,
        output o_Col,
        output o_Row,
        output o_Active,
        output o_Frame_Start,
        output o_Locked,
        output o_Err
    );

endinterface

// File: rtl/sync_edge_detect.sv
// Rising-edge detector for an active-low sync stream; the history register
// resets high so a line idling high at reset release yields no edge.
module sync_edge_detect (
    input  logic CLK,
    input  logic RST,
    input  logic sync_in,
    output logic rise
);

    logic sync_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= 1'b1;
        end else begin
            sync_q <= sync_in;
        end
    end

    assign rise = sync_in & ~sync_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from H/V sync pulses, checks line and frame
// lengths against nominal timing and tracks lock status.
module vga_sync_decoder import vga_timing_pkg::*; #(
    parameter int TOTAL_COLS  = H_TOTAL,
    parameter int TOTAL_ROWS  = V_TOTAL,
    parameter int ACTIVE_COLS = H_ACTIVE,
    parameter int ACTIVE_ROWS = V_ACTIVE,
    parameter int LOCK_FRAMES = DEFAULT_LOCK_FRAMES
) (
    input  logic                 CLK,
    input  logic                 RST,
    vga_sync_decoder_if.slave    bus
);

    localparam int COL_W = $clog2(TOTAL_COLS);
    localparam int ROW_W = $clog2(TOTAL_ROWS);
    localparam int CNT_W = count_bits(LOCK_FRAMES + 1);

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(TOTAL_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(TOTAL_ROWS - 1);
    localparam logic [COL_W-1:0] COL_ACTIVE = COL_W'(ACTIVE_COLS);
    localparam logic [ROW_W-1:0] ROW_ACTIVE = ROW_W'(ACTIVE_ROWS);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(LOCK_FRAMES - 1);

    logic             h_rise;
    logic             v_rise;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             v_pend;
    lock_state_t      state;
    logic [CNT_W-1:0] good_cnt;
    logic             err_q;
    logic             frame_start_q;

    logic             v_apply;
    logic             col_last;
    logic             row_last;
    logic             line_err;
    logic             frame_err;
    logic             timing_err;

    sync_edge_detect u_h_edge (
        .CLK     (CLK),
        .RST     (RST),
        .sync_in (bus.i_H_sync),
        .rise    (h_rise)
    );

    sync_edge_detect u_v_edge (
        .CLK     (CLK),
        .RST     (RST),
        .sync_in (bus.i_V_sync),
        .rise    (v_rise)
    );

    // A V edge takes effect on the H rise that ends the current line; a V
    // rise coinciding with that H rise is applied directly.
    always_comb begin
        v_apply    = h_rise & (v_pend | v_rise);
        col_last   = (col == COL_LAST);
        row_last   = (row == ROW_LAST);
        line_err   = h_rise ? ~col_last : col_last;
        frame_err  = v_apply ? ~row_last : (h_rise & row_last);
        timing_err = line_err | frame_err;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            col <= '0;
        end else if (h_rise || col_last) begin
            col <= '0;
        end else begin
            col <= col + COL_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            row    <= '0;
            v_pend <= 1'b0;
        end else begin
            if (v_apply) begin
                row <= '0;
            end else if (h_rise) begin
                row <= row_last ? '0 : row + ROW_W'(1);
            end
            if (h_rise) begin
                v_pend <= 1'b0;
            end else if (v_rise) begin
                v_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q         <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            err_q         <= timing_err & (state != UNLOCKED);
            frame_start_q <= v_apply;
        end
    end

    // Errors only matter once a frame boundary has been seen; until then the
    // counters are still finding their phase.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= UNLOCKED;
            good_cnt <= '0;
        end else begin
            case (state)
                UNLOCKED: begin
                    if (v_apply) begin
                        state    <= TRACKING;
                        good_cnt <= '0;
                    end
                end
                TRACKING: begin
                    if (timing_err) begin
                        state <= UNLOCKED;
                    end else if (v_apply) begin
                        if (good_cnt == CNT_LAST) begin
                            state <= LOCKED;
                        end
                        good_cnt <= good_cnt + CNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (timing_err) begin
                        state <= UNLOCKED;
                    end
                end
                default: begin
                    state <= UNLOCKED;
                end
            endcase
        end
    end

    assign bus.o_Col         = col;
    assign bus.o_Row         = row;
    assign bus.o_Locked      = (state == LOCKED);
    assign bus.o_Active      = (state == LOCKED) && (col < COL_ACTIVE) && (row < ROW_ACTIVE);
    assign bus.o_Frame_Start = frame_start_q;
    assign bus.o_Err         = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Self-checking bench for vga_sync_decoder using a reduced 40x20 raster so
// that several full lock/unlock sequences fit in a short run.
module tb_vga_sync_decoder;

    localparam int TC = 40;
    localparam int TR = 20;
    localparam int AC = 32;
    localparam int AR = 15;
    localparam int LF = 2;
    localparam int HS = 8;
    localparam int VS = 3;
    localparam int ACTIVE_PER_FRAME = 480;

    logic CLK = 1'b0;
    logic RST;

    int checkCount = 0;
    int errorCount = 0;
    int activeSeen = 0;
    int fsSeen     = 0;
    int errSeen    = 0;
    bit compareEn  = 1'b0;

    always #5 CLK = ~CLK;

    vga_sync_decoder_if #(.TOTAL_COLS(TC), .TOTAL_ROWS(TR)) bus ();

    vga_sync_decoder #(
        .TOTAL_COLS  (TC),
        .TOTAL_ROWS  (TR),
        .ACTIVE_COLS (AC),
        .ACTIVE_ROWS (AR),
        .LOCK_FRAMES (LF)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Reference: good < 0 means no frame boundary seen yet, otherwise it is
    // the number of clean frames since the last boundary, capped at LF.
    typedef struct {
        int col;
        int row;
        int good;
        bit pend;
        bit hPrev;
        bit vPrev;
        bit err;
        bit fs;
    } modelState_t;

    modelState_t m;

    function automatic modelState_t modelReset();
        modelState_t r;
        r.col = 0; r.row = 0; r.good = -1; r.pend = 1'b0;
        r.hPrev = 1'b1; r.vPrev = 1'b1; r.err = 1'b0; r.fs = 1'b0;
        return r;
    endfunction

    function automatic modelState_t modelNext(input modelState_t s, input bit h, input bit v);
        modelState_t n;
        bit hRise, vRise, applyV, lineBad, frameBad, bad;
        n        = s;
        hRise    = h && !s.hPrev;
        vRise    = v && !s.vPrev;
        applyV   = hRise && (s.pend || vRise);
        lineBad  = hRise ? (s.col != TC - 1) : (s.col == TC - 1);
        frameBad = applyV ? (s.row != TR - 1) : (hRise && s.row == TR - 1);
        bad      = lineBad || frameBad;
        n.hPrev  = h;
        n.vPrev  = v;
        n.col    = hRise ? 0 : (s.col + 1) % TC;
        n.row    = applyV ? 0 : (hRise ? (s.row + 1) % TR : s.row);
        n.pend   = hRise ? 1'b0 : (s.pend || vRise);
        n.err    = (s.good >= 0) && bad;
        n.fs     = applyV;
        if (s.good < 0) n.good = applyV ? 0 : -1;
        else if (bad) n.good = -1;
        else if (applyV && s.good < LF) n.good = s.good + 1;
        return n;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) m <= modelReset();
        else     m <= modelNext(m, bus.i_H_sync, bus.i_V_sync);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (compareEn) begin
            checkOutput("col", 32'(bus.o_Col), m.col);
            checkOutput("row", 32'(bus.o_Row), m.row);
            checkOutput("locked", 32'(bus.o_Locked), 32'(m.good >= LF));
            checkOutput("active", 32'(bus.o_Active), 32'(m.good >= LF && m.col < AC && m.row < AR));
            checkOutput("frame_start", 32'(bus.o_Frame_Start), 32'(m.fs));
            checkOutput("err", 32'(bus.o_Err), 32'(m.err));
            if (bus.o_Active)      activeSeen <= activeSeen + 1;
            if (bus.o_Frame_Start) fsSeen     <= fsSeen + 1;
            if (bus.o_Err)         errSeen    <= errSeen + 1;
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_col"}, 32'(bus.o_Col), 0);
        checkOutput({tag, "_row"}, 32'(bus.o_Row), 0);
        checkOutput({tag, "_active"}, 32'(bus.o_Active), 0);
        checkOutput({tag, "_fs"}, 32'(bus.o_Frame_Start), 0);
        checkOutput({tag, "_locked"}, 32'(bus.o_Locked), 0);
        checkOutput({tag, "_err"}, 32'(bus.o_Err), 0);
    endtask

    task automatic applyStimulus(input bit h, input bit v);
        bus.i_H_sync = h;
        bus.i_V_sync = v;
        @(posedge CLK);
        #1;
    endtask

    // H is low for HS columns and returns high on the last column of the line.
    function automatic bit hLevel(input int c, input int len, input bit pulse);
        return !(pulse && c >= len - 1 - HS && c <= len - 2);
    endfunction

    // V is low for VS rows and returns high at column lastVLow of the last row.
    function automatic bit vLevel(input int row, input int c, input int lastVLow);
        if (row >= TR - 1 - VS && row <= TR - 2) return 1'b0;
        if (row == TR - 1) return !(c < lastVLow);
        return 1'b1;
    endfunction

    task automatic runLinePart(input int row, input int c0, input int c1, input int len,
                               input bit pulse, input int lastVLow);
        for (int c = c0; c <= c1; c++) applyStimulus(hLevel(c, len, pulse), vLevel(row, c, lastVLow));
    endtask

    task automatic runRows(input int r0, input int r1, input int lastVLow);
        for (int r = r0; r <= r1; r++) runLinePart(r, 0, TC - 1, TC, 1'b1, lastVLow);
    endtask

    task automatic runFrame(input int lastVLow);
        runRows(0, TR - 1, lastVLow);
    endtask

    initial begin
        #2_000_000;
        errorCount++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        int a0, f0, e0;
        RST = 1'b1;
        bus.i_H_sync = 1'b1;
        bus.i_V_sync = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        compareEn = 1'b1;
        checkAllZero("reset");
        RST = 1'b0;

        e0 = errSeen; f0 = fsSeen;
        repeat (1000) applyStimulus(1'b1, 1'b1);
        checkOutput("idle_err_pulses", errSeen - e0, 0);
        checkOutput("idle_fs_pulses", fsSeen - f0, 0);
        checkAllZero("idle");

        // Acquire lock: first boundary, then two clean frames.
        runFrame(0);
        runFrame(0);
        checkOutput("lock_after_2_edges", 32'(bus.o_Locked), 0);
        runFrame(0);
        checkOutput("lock_after_3_edges", 32'(bus.o_Locked), 1);
        checkOutput("lock_fs", 32'(bus.o_Frame_Start), 1);
        checkOutput("lock_col", 32'(bus.o_Col), 0);
        checkOutput("lock_row", 32'(bus.o_Row), 0);

        a0 = activeSeen; f0 = fsSeen; e0 = errSeen;
        runFrame(0);
        checkOutput("frame_active_cycles", activeSeen - a0, ACTIVE_PER_FRAME);
        checkOutput("frame_fs_pulses", fsSeen - f0, 1);
        checkOutput("frame_err_pulses", errSeen - e0, 0);
        checkOutput("frame_locked", 32'(bus.o_Locked), 1);

        // Short line: H rise two columns early.
        e0 = errSeen;
        runRows(0, 4, 0);
        runLinePart(5, 0, TC - 3, TC - 2, 1'b1, 0);
        checkOutput("short_err", 32'(bus.o_Err), 1);
        checkOutput("short_locked", 32'(bus.o_Locked), 0);
        checkOutput("short_col", 32'(bus.o_Col), 0);
        checkOutput("short_row", 32'(bus.o_Row), 6);
        runLinePart(6, 0, 0, TC, 1'b1, 0);
        checkOutput("short_err_width", 32'(bus.o_Err), 0);
        runLinePart(6, 1, TC - 1, TC, 1'b1, 0);
        runRows(7, TR - 1, 0);
        runFrame(0);
        checkOutput("short_relock_2", 32'(bus.o_Locked), 0);
        runFrame(0);
        checkOutput("short_relock_3", 32'(bus.o_Locked), 1);
        checkOutput("short_err_pulses", errSeen - e0, 1);

        // V rise mid-way through the last row.
        runRows(0, TR - 2, 5);
        runLinePart(TR - 1, 0, 20, TC, 1'b1, 5);
        checkOutput("vmid_row_held", 32'(bus.o_Row), TR - 1);
        checkOutput("vmid_col", 32'(bus.o_Col), 21);
        runLinePart(TR - 1, 21, TC - 1, TC, 1'b1, 5);
        checkOutput("vmid_row", 32'(bus.o_Row), 0);
        checkOutput("vmid_col0", 32'(bus.o_Col), 0);
        checkOutput("vmid_fs", 32'(bus.o_Frame_Start), 1);
        checkOutput("vmid_err", 32'(bus.o_Err), 0);
        checkOutput("vmid_locked", 32'(bus.o_Locked), 1);

        // V and H rising on the same edge.
        runRows(0, TR - 2, TC - 1);
        runLinePart(TR - 1, 0, TC - 1, TC, 1'b1, TC - 1);
        checkOutput("vsame_row", 32'(bus.o_Row), 0);
        checkOutput("vsame_col", 32'(bus.o_Col), 0);
        checkOutput("vsame_err", 32'(bus.o_Err), 0);
        checkOutput("vsame_locked", 32'(bus.o_Locked), 1);

        // Missing H pulse: column freewheels through the wrap.
        e0 = errSeen;
        runRows(0, 6, 0);
        runLinePart(7, 0, TC - 1, TC, 1'b0, 0);
        checkOutput("miss_err", 32'(bus.o_Err), 1);
        checkOutput("miss_col", 32'(bus.o_Col), 0);
        checkOutput("miss_row", 32'(bus.o_Row), 7);
        checkOutput("miss_locked", 32'(bus.o_Locked), 0);
        runRows(8, TR - 1, 0);
        checkOutput("miss_unlocked_noerr", 32'(bus.o_Err), 0);
        runFrame(0);
        checkOutput("miss_relock_2", 32'(bus.o_Locked), 0);
        runFrame(0);
        checkOutput("miss_relock_3", 32'(bus.o_Locked), 1);
        checkOutput("miss_err_pulses", errSeen - e0, 1);

        // Asynchronous reset in the middle of an active line.
        runRows(0, 9, 0);
        runLinePart(10, 0, 19, TC, 1'b1, 0);
        checkOutput("pre_rst_row", 32'(bus.o_Row), 10);
        checkOutput("pre_rst_col", 32'(bus.o_Col), 20);
        checkOutput("pre_rst_active", 32'(bus.o_Active), 1);
        #2;
        RST = 1'b1;
        #1;
        checkAllZero("async_rst");
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        runFrame(0);
        runFrame(0);
        checkOutput("rst_relock_2", 32'(bus.o_Locked), 0);
        runFrame(0);
        checkOutput("rst_relock_3", 32'(bus.o_Locked), 1);
        checkOutput("rst_relock_fs", 32'(bus.o_Frame_Start), 1);

        compareEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA sync pulse generator. Takes the active-low H and V sync pulse streams and recovers the column and row pixel coordinates, an active-video flag and a frame-start strobe. It checks every line and frame length against the expected timing and reports lock status. It sits between a sync source (the local generator or an external video input already in the CLK domain) and pixel consumers such as pattern generators and frame-buffer readers.

## Interface
- TOTAL_COLS, 800, pixel clocks per line
- TOTAL_ROWS, 525, lines per frame
- ACTIVE_COLS, 640, visible columns (0..ACTIVE_COLS-1)
- ACTIVE_ROWS, 480, visible rows
- LOCK_FRAMES, 2, consecutive good frames needed to assert lock
- CLK  in  1  pixel clock; single clock domain
- RST  in  1  reset, asynchronous, active-high
- i_H_sync  in  1  horizontal sync; low = sync interval
- i_V_sync  in  1  vertical sync; low = sync interval
- o_Col  out  $clog2(TOTAL_COLS)  recovered column
- o_Row  out  $clog2(TOTAL_ROWS)  recovered row
- o_Active  out  1  o_Locked && o_Col<ACTIVE_COLS && o_Row<ACTIVE_ROWS
- o_Frame_Start  out  1  one-cycle strobe, high while o_Col==0 && o_Row==0 after an applied V edge
- o_Locked  out  1  timing lock
- o_Err  out  1  one-cycle strobe on a length violation while TRACKING or LOCKED

## Operation
- Edge detect: registered copies h_q and v_q. H rise = i_H_sync && !h_q. V rise = i_V_sync && !v_q.
- Column: H rise → col <= 0. Otherwise col increments, wrapping TOTAL_COLS-1 → 0 (freewheel).
- Row: increments on each H rise, wrapping TOTAL_ROWS-1 → 0. V rise sets v_pend.
- Applying a V edge: at the next H rise with v_pend set, row <= 0 and v_pend clears. If V rise and H rise occur on the same edge, row <= 0 immediately and v_pend is not set.
- Line error:
  - H rise with col != TOTAL_COLS-1, or
  - col == TOTAL_COLS-1 with no H rise on that edge (missing edge).
- Frame error:
  - V edge applied with row != TOTAL_ROWS-1, or
  - H rise with row == TOTAL_ROWS-1 and no V edge applied (missing V).
- FSM states UNLOCKED, TRACKING, LOCKED:
  - UNLOCKED: errors ignored and o_Err stays 0. First applied V edge → TRACKING, good-frame count = 0.
  - TRACKING: each applied V edge with no error since the previous one increments the count. When the count reaches LOCK_FRAMES → LOCKED. Any error → UNLOCKED.
  - LOCKED: any error → UNLOCKED and o_Err pulses.
  - o_Err also pulses on an error in TRACKING.
- o_Locked = (state == LOCKED).
- Counters keep running in every state.

## Timing
- Reset values:
  - o_Col=0, o_Row=0, o_Active=0, o_Frame_Start=0, o_Locked=0, o_Err=0
  - state=UNLOCKED, v_pend=0, good-frame count=0
  - h_q=1, v_q=1, so a high input at reset release produces no edge.
- Latency: o_Col=0 in the cycle after the CLK edge that first samples i_H_sync high following a low. o_Row, o_Frame_Start, o_Err and o_Locked update on that same edge.
- o_Active is combinational from registered o_Col, o_Row and state, so it is aligned with the coordinates.
- o_Err and o_Frame_Start are exactly one cycle wide.
- Reset asserted mid-frame forces all outputs to reset values immediately. After release, lock is reacquired from UNLOCKED.
- Counter widths: col compares against TOTAL_COLS-1 only, never overflows its width; same for row.

## Structure
- Package vga_timing_pkg holds:
  - default constants H_TOTAL=800, H_ACTIVE=640, V_TOTAL=525, V_ACTIVE=480
  - the lock FSM state typedef (UNLOCKED, TRACKING, LOCKED)
  - these are shared with the sync generator.
- Sub-module sync_edge_detect (1-bit register plus rise output, reset value 1), instantiated for H and V.
- Top level holds the counters, v_pend, the error checks and the FSM.

## Test plan
- Reset with inputs high, then release → all outputs 0, no o_Err or o_Frame_Start for 1000 cycles.
- Nominal 800x525 stream (sync low for 160 cols and 45 rows):
  - o_Locked rises one cycle after the third applied V edge (first edge → TRACKING, then 2 good frames).
  - Each locked frame has exactly 307200 o_Active cycles and exactly one o_Frame_Start.
- While locked, one line with H rise at col 797 → o_Err pulses once, o_Locked drops on the same cycle, o_Col=0. Lock returns after LOCK_FRAMES+1 further clean V edges.
- V rise at col 100 of row 524 → row stays 524 until the next H rise, then row=0, col=0. V and H rising on the same edge → row=0, col=0 one cycle later, no error.
- While locked, one H pulse suppressed → col wraps 799→0, o_Err pulses at the wrap, state UNLOCKED.
- RST asserted at row 200, col 300 for 3 cycles → all outputs 0 without waiting for a CLK edge. Relock follows the nominal sequence.
